// File: rtl/hw5_alu_arbiter.sv
// Shares one pipelined hw5_unit ALU among four requesters with round-robin issue;
// each result is routed back to its owner through the {id, seq} tag carried by the ALU.
module hw5_alu_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DATABITS = 7,
  parameter int unsigned MAX_OUT  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_arg1,
  input  logic [WIDTH*NREQ-1:0] req_arg2,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [1:0]            alu_op,
  output logic [DATABITS-1:0]   alu_tag,
  input  logic [WIDTH-1:0]      alu_res,
  input  logic [1:0]            alu_out_op,
  input  logic [DATABITS-1:0]   alu_out_tag,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [1:0]            rsp_op,
  output logic [DATABITS-3:0]   rsp_seq,
  output logic                  idle,
  output logic                  err_spurious
);

  localparam int unsigned IDW  = 2;
  localparam int unsigned SEQW = DATABITS - IDW;
  localparam int unsigned CNTW = 4;
  localparam int unsigned OPW  = 2;
  localparam logic [OPW-1:0] OP_NOP = '0;

  typedef struct packed {
    logic [OPW-1:0]      op;
    logic [DATABITS-1:0] tag;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
  } issue_t;

  typedef struct packed {
    logic [NREQ-1:0]  valid;
    logic [WIDTH-1:0] result;
    logic [OPW-1:0]   op;
    logic [SEQW-1:0]  seq;
  } rsp_t;

  logic [IDW-1:0]             rr_q, rr_d;
  logic [NREQ-1:0][SEQW-1:0]  seq_q, seq_d;
  logic [NREQ-1:0][CNTW-1:0]  cnt_q, cnt_d;
  issue_t                     issue_q, issue_d;
  rsp_t                       rsp_q, rsp_d;
  logic                       err_q, err_d;

  logic [NREQ-1:0][OPW-1:0]   op_c;
  logic [NREQ-1:0][WIDTH-1:0] arg1_c;
  logic [NREQ-1:0][WIDTH-1:0] arg2_c;
  logic [NREQ-1:0]            elig_c;
  logic                       grant_any_c;
  logic [IDW-1:0]             grant_id_c;
  logic [IDW-1:0]             scan_idx_c;
  logic                       ret_any_c;
  logic [IDW-1:0]             ret_id_c;

  assign op_c   = req_op;
  assign arg1_c = req_arg1;
  assign arg2_c = req_arg2;

  assign ret_any_c = (alu_out_op != OP_NOP);
  assign ret_id_c  = alu_out_tag[DATABITS-1 -: IDW];

  // Round-robin scan from rr_q; iterating downward lets the closest eligible index win.
  always_comb begin
    elig_c      = '0;
    grant_any_c = 1'b0;
    grant_id_c  = rr_q;
    scan_idx_c  = '0;
    req_ready   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      elig_c[i] = req_valid[i] && (op_c[i] != OP_NOP) && (cnt_q[i] < CNTW'(MAX_OUT));
    end
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      scan_idx_c = rr_q + IDW'(k);
      if (elig_c[scan_idx_c]) begin
        grant_any_c = 1'b1;
        grant_id_c  = scan_idx_c;
      end
    end
    if (grant_any_c) begin
      req_ready = NREQ'(1) << grant_id_c;
    end
  end

  always_comb begin
    rr_d    = rr_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    issue_d = '0;
    rsp_d   = rsp_q;
    err_d   = err_q;

    rsp_d.valid = '0;

    if (grant_any_c) begin
      issue_d.op             = op_c[grant_id_c];
      issue_d.a              = arg1_c[grant_id_c];
      issue_d.b              = arg2_c[grant_id_c];
      issue_d.tag            = {grant_id_c, seq_q[grant_id_c]};
      seq_d[grant_id_c]      = seq_q[grant_id_c] + SEQW'(1);
      rr_d                   = grant_id_c + IDW'(1);
    end

    if (ret_any_c) begin
      rsp_d.valid[ret_id_c] = 1'b1;
      rsp_d.result          = alu_res;
      rsp_d.op              = alu_out_op;
      rsp_d.seq             = alu_out_tag[SEQW-1:0];
      if (cnt_q[ret_id_c] == '0) begin
        err_d = 1'b1;
      end
    end

    // Accept and return on the same edge cancel; a return never underflows a zero count.
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_any_c && (grant_id_c == IDW'(i))) begin
        cnt_d[i] = cnt_d[i] + CNTW'(1);
      end
      if (ret_any_c && (ret_id_c == IDW'(i)) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_d[i] - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q    <= '0;
      seq_q   <= '0;
      cnt_q   <= '0;
      issue_q <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      issue_q <= issue_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
    end
  end

  assign alu_a        = issue_q.a;
  assign alu_b        = issue_q.b;
  assign alu_op       = issue_q.op;
  assign alu_tag      = issue_q.tag;
  assign rsp_valid    = rsp_q.valid;
  assign rsp_result   = rsp_q.result;
  assign rsp_op       = rsp_q.op;
  assign rsp_seq      = rsp_q.seq;
  assign err_spurious = err_q;
  assign idle         = (cnt_q == '0) && (issue_q.op == OP_NOP);

endmodule

// File: tb/tb_hw5_alu_arbiter.sv
// Bench for hw5_alu_arbiter: directed stimulus, a queue-based ALU stand-in, and a
// per-cycle behavioural model of the arbitration and routing rules.
module tb_hw5_alu_arbiter;

  localparam int MAXO = 2;

  logic         clk, rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [7:0]   req_op;
  logic [127:0] req_arg1, req_arg2;
  logic [31:0]  alu_a, alu_b, alu_res;
  logic [1:0]   alu_op, alu_out_op;
  logic [6:0]   alu_tag, alu_out_tag;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_result;
  logic [1:0]   rsp_op;
  logic [4:0]   rsp_seq;
  logic         idle, err_spurious;

  hw5_alu_arbiter #(.MAX_OUT(MAXO)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_arg1(req_arg1), .req_arg2(req_arg2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_tag(alu_tag),
    .alu_res(alu_res), .alu_out_op(alu_out_op), .alu_out_tag(alu_out_tag),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_seq(rsp_seq),
    .idle(idle), .err_spurious(err_spurious)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ALU stand-in: queue of results, released automatically, one at a time, or overridden.
  typedef struct packed {
    logic [6:0]  tag;
    logic [1:0]  op;
    logic [31:0] res;
  } alu_e_t;

  alu_e_t alu_q[$];
  alu_e_t ae, ao;
  bit auto_rel, rel_one, force_en;
  logic [1:0]  f_op;
  logic [6:0]  f_tag;
  logic [31:0] f_res;

  function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd1:    return a + b;
      2'd2:    return a - b;
      2'd3:    return a * b;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q.delete();
      alu_out_op  <= 2'd0;
      alu_out_tag <= 7'd0;
      alu_res     <= 32'd0;
    end else begin
      if (alu_op != 2'd0) begin
        ae.tag = alu_tag;
        ae.op  = alu_op;
        ae.res = alu_fn(alu_op, alu_a, alu_b);
        alu_q.push_back(ae);
      end
      if (force_en) begin
        alu_out_op  <= f_op;
        alu_out_tag <= f_tag;
        alu_res     <= f_res;
      end else if (alu_q.size() > 0 && (auto_rel || rel_one)) begin
        ao = alu_q.pop_front();
        alu_out_op  <= ao.op;
        alu_out_tag <= ao.tag;
        alu_res     <= ao.res;
      end else begin
        alu_out_op <= 2'd0;
      end
    end
  end

  // Behavioural model of the arbiter, kept in plain integers.
  int          m_cnt[4], m_seq[4];
  int          m_rr, m_g, m_j;
  bit          m_err;
  logic [1:0]  m_aop, m_rop;
  logic [6:0]  m_atag;
  logic [31:0] m_a, m_b, m_rres;
  logic [3:0]  m_rv;
  logic [4:0]  m_rseq;

  function automatic int pick();
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_rr + k) % 4;
      if (req_valid[i] && req_op[2*i +: 2] != 2'd0 && m_cnt[i] < MAXO) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0;
        m_seq[i] = 0;
      end
      m_rr = 0; m_err = 1'b0;
      m_aop = 2'd0; m_atag = 7'd0; m_a = 32'd0; m_b = 32'd0;
      m_rv = 4'd0; m_rres = 32'd0; m_rop = 2'd0; m_rseq = 5'd0;
    end else begin
      m_g = pick();
      if (m_g >= 0) begin
        m_aop    = req_op[2*m_g +: 2];
        m_a      = req_arg1[32*m_g +: 32];
        m_b      = req_arg2[32*m_g +: 32];
        m_atag   = 7'(m_g * 32 + m_seq[m_g]);
        m_seq[m_g] = (m_seq[m_g] + 1) % 32;
        m_rr     = (m_g + 1) % 4;
      end else begin
        m_aop = 2'd0; m_atag = 7'd0; m_a = 32'd0; m_b = 32'd0;
      end
      m_rv = 4'd0;
      if (alu_out_op != 2'd0) begin
        m_j    = int'(alu_out_tag) / 32;
        m_rv   = 4'(1 << m_j);
        m_rres = alu_res;
        m_rop  = alu_out_op;
        m_rseq = 5'(int'(alu_out_tag) % 32);
        if (m_cnt[m_j] == 0) m_err = 1'b1;
        else m_cnt[m_j]--;
      end
      if (m_g >= 0) m_cnt[m_g]++;
    end
  end

  bit chk_en;

  always @(negedge clk) begin : cmp
    int g;
    bit all_zero;
    if (chk_en) begin
      g = pick();
      all_zero = (m_cnt[0] == 0) && (m_cnt[1] == 0) && (m_cnt[2] == 0) && (m_cnt[3] == 0);
      chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("alu_op", 32'(alu_op), 32'(m_aop));
      chk("alu_tag", 32'(alu_tag), 32'(m_atag));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("rsp_result", rsp_result, m_rres);
      chk("rsp_op", 32'(rsp_op), 32'(m_rop));
      chk("rsp_seq", 32'(rsp_seq), 32'(m_rseq));
      chk("idle", 32'(idle), 32'(all_zero && m_aop == 2'd0));
      chk("err_spurious", 32'(err_spurious), 32'(m_err));
    end
  end

  task automatic set_req(input int i, input bit v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]         = v;
    req_op[2*i +: 2]     = op;
    req_arg1[32*i +: 32] = a;
    req_arg2[32*i +: 32] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  logic [6:0] rr_tags [5];
  int n_iss;
  bit wrap_done;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rr_tags = '{7'h20, 7'h40, 7'h60, 7'h01, 7'h21};
    req_valid = '0; req_op = '0; req_arg1 = '0; req_arg2 = '0;
    auto_rel = 1'b1; rel_one = 1'b0; force_en = 1'b0;
    f_op = 2'd0; f_tag = 7'd0; f_res = 32'd0; chk_en = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_tag", 32'(alu_tag), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_err", 32'(err_spurious), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Single ADD from requester 0
    set_req(0, 1'b1, 2'd1, 32'd5, 32'd7);
    probe(); chk("t1_ready", 32'(req_ready), 32'h1);
    tick(); set_req(0, 1'b0, 2'd0, 32'd0, 32'd0);
    probe(); chk("t1_alu_op", 32'(alu_op), 32'd1);
    chk("t1_alu_tag", 32'(alu_tag), 32'h00);
    chk("t1_idle_busy", 32'(idle), 32'd0);
    tick(); probe(); chk("t1_no_rsp_yet", 32'(rsp_valid), 32'h0);
    tick(); probe(); chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_result", rsp_result, 32'd12);
    chk("t1_rsp_seq", 32'(rsp_seq), 32'd0);
    chk("t1_idle", 32'(idle), 32'd1);
    tick(); probe(); chk("t1_pulse_end", 32'(rsp_valid), 32'h0);

    // Round-robin among four SUB requesters
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'd2, 32'(20 + 10 * i), 32'(i + 1));
    for (int k = 0; k < 5; k++) begin
      tick(); probe();
      chk("t2_rr_tag", 32'(alu_tag), 32'(rr_tags[k]));
      chk("t2_rr_op", 32'(alu_op), 32'd2);
    end
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'd0, 32'd0, 32'd0);
    repeat (5) tick();

    // Credit limit with the ALU holding its results
    auto_rel = 1'b0;
    set_req(1, 1'b1, 2'd1, 32'd1, 32'd2);
    probe(); chk("t3_ready_a", 32'(req_ready), 32'h2);
    tick(); probe(); chk("t3_ready_b", 32'(req_ready), 32'h2);
    tick(); probe(); chk("t3_full", 32'(req_ready), 32'h0);
    tick(); set_req(2, 1'b1, 2'd1, 32'd3, 32'd4);
    probe(); chk("t3_req2_passes", 32'(req_ready), 32'h4);
    tick(); set_req(2, 1'b0, 2'd0, 32'd0, 32'd0);
    probe(); chk("t3_still_full", 32'(req_ready), 32'h0);
    tick(); rel_one = 1'b1;
    tick(); rel_one = 1'b0;
    probe(); chk("t3_pre_rsp", 32'(rsp_valid), 32'h0);
    chk("t3_pre_ready", 32'(req_ready), 32'h0);
    tick(); probe(); chk("t3_rsp", 32'(rsp_valid), 32'h2);
    chk("t3_rsp_result", rsp_result, 32'd3);
    chk("t3_reenabled", 32'(req_ready), 32'h2);
    tick(); set_req(1, 1'b0, 2'd0, 32'd0, 32'd0);
    auto_rel = 1'b1;
    repeat (6) tick();

    // Asynchronous reset with three ops outstanding
    auto_rel = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 2'd1, 32'(i), 32'd1);
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 2'd0, 32'd0, 32'd0);
    probe(); chk("t4_busy", 32'(idle), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_alu_op", 32'(alu_op), 32'd0);
    chk("t4_alu_tag", 32'(alu_tag), 32'd0);
    chk("t4_alu_a", alu_a, 32'd0);
    chk("t4_alu_b", alu_b, 32'd0);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t4_rsp_result", rsp_result, 32'd0);
    chk("t4_rsp_op", 32'(rsp_op), 32'd0);
    chk("t4_rsp_seq", 32'(rsp_seq), 32'd0);
    chk("t4_idle", 32'(idle), 32'd1);
    chk("t4_err", 32'(err_spurious), 32'd0);
    tick(); rst_n = 1'b1; auto_rel = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'd1, 32'd9, 32'd9);
    probe(); chk("t4_first_grant", 32'(req_ready), 32'h1);
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'd0, 32'd0, 32'd0);
    probe(); chk("t4_first_tag", 32'(alu_tag), 32'h00);
    repeat (5) tick();

    // Sequence wrap on requester 3
    set_req(3, 1'b1, 2'd1, 32'd100, 32'd1);
    n_iss = 0; wrap_done = 1'b0;
    for (int c = 0; c < 150 && !wrap_done; c++) begin
      probe();
      if (alu_op != 2'd0) begin
        n_iss++;
        if (n_iss == 32) chk("t5_tag32", 32'(alu_tag), 32'h7F);
        if (n_iss == 33) begin
          chk("t5_tag33", 32'(alu_tag), 32'h60);
          wrap_done = 1'b1;
        end
      end
      tick();
    end
    if (!wrap_done) chk("t5_timeout_issues", 32'(n_iss), 32'd33);
    set_req(3, 1'b0, 2'd0, 32'd0, 32'd0);
    repeat (6) tick();

    // Spurious return for requester 1 with nothing outstanding
    force_en = 1'b1; f_op = 2'd3; f_tag = 7'h25; f_res = 32'hDEAD;
    tick(); force_en = 1'b0;
    probe(); chk("t6_err_pre", 32'(err_spurious), 32'd0);
    tick(); probe();
    chk("t6_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("t6_rsp_op", 32'(rsp_op), 32'd3);
    chk("t6_rsp_seq", 32'(rsp_seq), 32'd5);
    chk("t6_rsp_result", rsp_result, 32'hDEAD);
    chk("t6_err", 32'(err_spurious), 32'd1);
    tick(); probe();
    chk("t6_err_sticky", 32'(err_spurious), 32'd1);
    chk("t6_pulse_end", 32'(rsp_valid), 32'h0);
    chk("t6_hold_result", rsp_result, 32'hDEAD);

    // Accept and return for requester 1 on the same edge
    tick(); auto_rel = 1'b0;
    set_req(1, 1'b1, 2'd1, 32'd8, 32'd9);
    tick(); set_req(1, 1'b0, 2'd0, 32'd0, 32'd0); rel_one = 1'b1;
    tick(); rel_one = 1'b0; set_req(1, 1'b1, 2'd1, 32'd10, 32'd11);
    probe(); chk("t7_ready_one_out", 32'(req_ready), 32'h2);
    tick(); set_req(1, 1'b0, 2'd0, 32'd0, 32'd0);
    probe(); chk("t7_rsp", 32'(rsp_valid), 32'h2);
    chk("t7_rsp_result", rsp_result, 32'd17);
    chk("t7_busy", 32'(idle), 32'd0);
    tick(); set_req(1, 1'b1, 2'd1, 32'd1, 32'd1);
    probe(); chk("t7_count_kept", 32'(req_ready), 32'h2);
    tick(); probe(); chk("t7_now_full", 32'(req_ready), 32'h0);
    tick(); set_req(1, 1'b0, 2'd0, 32'd0, 32'd0); auto_rel = 1'b1;
    repeat (6) tick();
    probe(); chk("t7_idle", 32'(idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
